uart_port_fifo_bridge: RTL and testbench

- Port-mapped UART buffer between the PicoBlaze strobe decoder and the Rx/Tx engines.
- Adds parametrised-depth RX and TX FIFOs, sticky error capture with clear-on-read, a control register, and a level interrupt.
- Replaces the single-byte rxdata/txdata buffering and the direct status mux path.
- The automatic TX drain FSM frees firmware from polling Tx_rdy per byte.

---
 rtl/uart_port_fifo_bridge_if.sv | 18 +
 rtl/uart_port_fifo_bridge.sv | 174 +++++++++++++++++
 tb/tb_uart_port_fifo_bridge.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_port_fifo_bridge_if.sv
// PicoBlaze port bus between the strobe decoder (master) and the UART buffer (slave).
interface uart_port_fifo_bridge_if;
    logic [7:0] port_id;
    logic       rd_strb;
    logic       wr_strb;
    logic [7:0] port_out_data;
    logic [7:0] port_in_data;

    modport master (
        output port_id, rd_strb, wr_strb, port_out_data,
        input  port_in_data
    );

    modport slave (
        input  port_id, rd_strb, wr_strb, port_out_data,
        output port_in_data
    );
endinterface

// File: rtl/uart_port_fifo_bridge.sv
// Port-mapped UART buffer: RX/TX FIFOs, sticky error capture, control register,
// level interrupt and an automatic TX drain engine feeding the TxEngine.
module uart_port_fifo_bridge #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [7:0]  BASE_ADDR  = 8'h00,
    parameter int unsigned RX_THRESH  = 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    uart_port_fifo_bridge_if.slave   pb,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     p_err,
    input  logic                     frm_err,
    input  logic                     ov_err,
    input  logic                     tx_rdy,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    output logic                     irq
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [CNT_W-1:0]      cnt_t;
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT_LOW, ST_WAIT_HIGH} state_t;

    logic [7:0] rx_mem [DEPTH];
    logic [7:0] tx_mem [DEPTH];
    ptr_t       rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
    cnt_t       rx_count, tx_count;
    logic       p_sticky, frm_sticky, ov_sticky, fovf_sticky;
    logic       rx_irq_en, tx_irq_en;
    state_t     state, state_nxt;
    logic       tx_pop;

    // Address decode relative to the base of the four-port window.
    logic [7:0] offs;
    logic       sel0, sel1, sel2, sel3;
    assign offs = pb.port_id - BASE_ADDR;
    assign sel0 = (offs == 8'd0);
    assign sel1 = (offs == 8'd1);
    assign sel2 = (offs == 8'd2);
    assign sel3 = (offs == 8'd3);

    logic rx_empty, rx_full, tx_empty, tx_full;
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == cnt_t'(DEPTH));
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == cnt_t'(DEPTH));

    logic ctrl_wr, rx_flush, tx_flush, err_clr;
    assign ctrl_wr  = pb.wr_strb & sel2;
    assign rx_flush = ctrl_wr & pb.port_out_data[0];
    assign tx_flush = ctrl_wr & pb.port_out_data[1];
    assign err_clr  = pb.rd_strb & sel2;

    // A pop on a full FIFO frees the slot for a same-cycle push.
    logic rx_pop, rx_push, rx_ovf, tx_wr, tx_push, tx_ovf;
    assign rx_pop  = pb.rd_strb & sel1 & ~rx_empty;
    assign rx_push = rx_valid & (~rx_full | rx_pop);
    assign rx_ovf  = rx_valid & rx_full & ~rx_pop & ~rx_flush;
    assign tx_wr   = pb.wr_strb & sel1;
    assign tx_push = tx_wr & (~tx_full | tx_pop);
    assign tx_ovf  = tx_wr & tx_full & ~tx_pop & ~tx_flush;

    always_ff @(posedge Clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
        if (tx_push) tx_mem[tx_wr_ptr] <= pb.port_out_data;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else if (rx_flush) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + ptr_t'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + ptr_t'(1);
            if (rx_push & ~rx_pop)      rx_count <= rx_count + cnt_t'(1);
            else if (~rx_push & rx_pop) rx_count <= rx_count - cnt_t'(1);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else if (tx_flush) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + ptr_t'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + ptr_t'(1);
            if (tx_push & ~tx_pop)      tx_count <= tx_count + cnt_t'(1);
            else if (~tx_push & tx_pop) tx_count <= tx_count - cnt_t'(1);
        end
    end

    // Sticky errors and control; a same-cycle set beats the read-clear.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            p_sticky    <= 1'b0;
            frm_sticky  <= 1'b0;
            ov_sticky   <= 1'b0;
            fovf_sticky <= 1'b0;
            rx_irq_en   <= 1'b0;
            tx_irq_en   <= 1'b0;
        end else begin
            p_sticky    <= (p_sticky    & ~err_clr) | p_err;
            frm_sticky  <= (frm_sticky  & ~err_clr) | frm_err;
            ov_sticky   <= (ov_sticky   & ~err_clr) | ov_err;
            fovf_sticky <= (fovf_sticky & ~err_clr) | rx_ovf | tx_ovf;
            if (ctrl_wr) begin
                rx_irq_en <= pb.port_out_data[2];
                tx_irq_en <= pb.port_out_data[3];
            end
        end
    end

    logic [7:0] status;
    assign status = {fovf_sticky, ov_sticky, frm_sticky, p_sticky,
                     tx_empty, rx_full, ~tx_full, ~rx_empty};

    always_comb begin
        pb.port_in_data = 8'h00;
        if (sel0)      pb.port_in_data = status;
        else if (sel1) pb.port_in_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
        else if (sel2) pb.port_in_data = {4'b0, fovf_sticky, ov_sticky, frm_sticky, p_sticky};
        else if (sel3) pb.port_in_data = 8'(rx_count);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Drain engine: hand one byte per TxEngine busy/idle round trip.
    always_comb begin
        state_nxt = state;
        tx_pop    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (~tx_empty & tx_rdy & ~tx_flush) begin
                    tx_pop    = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START:     state_nxt = ST_WAIT_LOW;
            ST_WAIT_LOW:  if (~tx_rdy) state_nxt = ST_WAIT_HIGH;
            ST_WAIT_HIGH: if (tx_rdy)  state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            irq      <= 1'b0;
        end else begin
            tx_start <= (state_nxt == ST_START);
            if (tx_pop) tx_data <= tx_mem[tx_rd_ptr];
            irq <= (rx_irq_en & (rx_count >= cnt_t'(RX_THRESH)))
                 | (tx_irq_en & tx_empty & (state == ST_IDLE));
        end
    end
endmodule

// File: tb/tb_uart_port_fifo_bridge.sv
// Directed bench for uart_port_fifo_bridge with a simple TxEngine ready model.
module tb_uart_port_fifo_bridge;
    localparam logic [7:0] BASE = 8'h40;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       p_err = 1'b0, frm_err = 1'b0, ov_err = 1'b0;
    logic       tx_rdy, tx_start, irq;
    logic [7:0] tx_data;
    logic       rdy_m = 1'b1;
    logic       tx_hold = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    uart_port_fifo_bridge_if pb ();

    assign tx_rdy = rdy_m & ~tx_hold;

    uart_port_fifo_bridge #(.DEPTH_LOG2(4), .BASE_ADDR(BASE), .RX_THRESH(4)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .pb       (pb),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .p_err    (p_err),
        .frm_err  (frm_err),
        .ov_err   (ov_err),
        .tx_rdy   (tx_rdy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .irq      (irq)
    );

    always #5 Clk = ~Clk;

    // TxEngine: goes busy the cycle after start, idle again 10 cycles later.
    always begin
        @(posedge Clk); #1;
        if (tx_start) begin
            @(posedge Clk); #1;
            rdy_m = 1'b0;
            repeat (10) begin @(posedge Clk); #1; end
            rdy_m = 1'b1;
        end
    end

    int         cyc = 0;
    int         pulse_cnt = 0;
    int         dbl_cnt = 0;
    int         pulse_cyc [8];
    logic [7:0] pulse_dat [8];
    logic       prev_start = 1'b0;

    always begin
        @(posedge Clk); #1;
        cyc++;
        if (tx_start) begin
            if (prev_start) dbl_cnt++;
            if (pulse_cnt < 8) begin
                pulse_cyc[pulse_cnt] = cyc;
                pulse_dat[pulse_cnt] = tx_data;
            end
            pulse_cnt++;
        end
        prev_start = tx_start;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    task automatic port_rd(input logic [7:0] off, output logic [7:0] d);
        pb.port_id = BASE + off;
        pb.rd_strb = 1'b1;
        #1 d = pb.port_in_data;
        tick(1);
        pb.rd_strb = 1'b0;
    endtask

    task automatic port_wr(input logic [7:0] off, input logic [7:0] d);
        pb.port_id       = BASE + off;
        pb.port_out_data = d;
        pb.wr_strb       = 1'b1;
        tick(1);
        pb.wr_strb = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k = 0;
        while (pulse_cnt < n && k < budget) begin
            tick(1);
            k++;
        end
        chk("tx_pulse_wait", 32'(pulse_cnt >= n), 32'd1);
    endtask

    initial begin
        logic [7:0] d;
        int         k;
        int         n0;
        pb.port_id       = 8'h00;
        pb.rd_strb       = 1'b0;
        pb.wr_strb       = 1'b0;
        pb.port_out_data = 8'h00;
        tick(3);
        Rst = 1'b0;
        tick(1);

        // Reset state
        port_rd(8'd0, d);      chk("rst_status", 32'(d), 32'h0A);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        pb.port_id = 8'h00;    #1 chk("unmapped_rd", 32'(pb.port_in_data), 32'h00);

        // Fill RX and overflow it
        for (int i = 0; i < 16; i++) rx_push(8'(8'h10 + i));
        rx_push(8'hAA);
        port_rd(8'd0, d);      chk("rx_full_status", 32'(d), 32'h8F);
        port_rd(8'd3, d);      chk("rx_full_count", 32'(d), 32'h10);
        port_rd(8'd2, d);      chk("err_ovf", 32'(d), 32'h08);
        port_rd(8'd2, d);      chk("err_cleared", 32'(d), 32'h00);

        // Push and pop together while full
        rx_data  = 8'h20;
        rx_valid = 1'b1;
        port_rd(8'd1, d);      chk("full_pushpop_rd", 32'(d), 32'h10);
        rx_valid = 1'b0;
        port_rd(8'd3, d);      chk("full_pushpop_count", 32'(d), 32'h10);
        port_rd(8'd2, d);      chk("full_pushpop_no_ovf", 32'(d), 32'h00);
        for (int i = 0; i < 16; i++) begin
            port_rd(8'd1, d);  chk($sformatf("rx_pop%0d", i), 32'(d), 32'(8'h11 + i));
        end
        port_rd(8'd1, d);      chk("rx_pop_empty", 32'(d), 32'h00);
        port_rd(8'd0, d);      chk("rx_empty_status", 32'(d), 32'h0A);

        // TX drain of two bytes with TX-empty interrupt
        port_wr(8'd1, 8'h55);
        port_wr(8'd1, 8'hA3);
        port_wr(8'd2, 8'h08);
        tick(1);               chk("tx_busy_irq", 32'(irq), 32'd0);
        k = 0;
        while (irq !== 1'b1 && k < 200) begin tick(1); k++; end
        chk("tx_irq_rise", 32'(irq), 32'd1);
        chk("tx_pulse_cnt", 32'(pulse_cnt), 32'd2);
        chk("tx_byte0", 32'(pulse_dat[0]), 32'h55);
        chk("tx_byte1", 32'(pulse_dat[1]), 32'hA3);
        chk("tx_gap_ge12", 32'((pulse_cyc[1] - pulse_cyc[0]) >= 12), 32'd1);
        chk("tx_start_width", 32'(dbl_cnt), 32'd0);
        port_wr(8'd2, 8'h00);
        tick(1);               chk("tx_irq_off", 32'(irq), 32'd0);

        // RX threshold interrupt and flush
        port_wr(8'd2, 8'h04);
        rx_push(8'h01); rx_push(8'h02); rx_push(8'h03);
        tick(1);               chk("rx_irq_below", 32'(irq), 32'd0);
        rx_push(8'h04);        chk("rx_irq_latency", 32'(irq), 32'd0);
        tick(1);               chk("rx_irq_at_thresh", 32'(irq), 32'd1);
        rx_data          = 8'h77;
        rx_valid         = 1'b1;
        pb.port_id       = BASE + 8'd2;
        pb.port_out_data = 8'h05;
        pb.wr_strb       = 1'b1;
        tick(1);
        rx_valid   = 1'b0;
        pb.wr_strb = 1'b0;
        tick(1);               chk("rx_flush_irq", 32'(irq), 32'd0);
        port_rd(8'd3, d);      chk("rx_flush_count", 32'(d), 32'h00);
        port_wr(8'd2, 8'h00);

        // Sticky capture; set during clearing read wins
        p_err = 1'b1; tick(1); p_err = 1'b0;
        frm_err = 1'b1;
        port_rd(8'd2, d);      chk("err_old_val", 32'(d), 32'h01);
        frm_err = 1'b0;
        port_rd(8'd2, d);      chk("err_frm_kept", 32'(d), 32'h02);
        ov_err = 1'b1; tick(1); ov_err = 1'b0;
        port_rd(8'd0, d);      chk("ov_status", 32'(d), 32'h4A);
        port_rd(8'd2, d);      chk("err_ov", 32'(d), 32'h04);
        port_rd(8'd2, d);      chk("err_clear2", 32'(d), 32'h00);

        // TX overflow while engine held busy, then flush
        tx_hold = 1'b1;
        n0 = pulse_cnt;
        for (int i = 0; i < 17; i++) port_wr(8'd1, 8'(8'hC0 + i));
        port_rd(8'd0, d);      chk("tx_full_status", 32'(d), 32'h80);
        port_wr(8'd2, 8'h02);
        port_rd(8'd0, d);      chk("tx_flush_status", 32'(d), 32'h8A);
        port_rd(8'd2, d);      chk("tx_err_ovf", 32'(d), 32'h08);
        tx_hold = 1'b0;
        tick(10);              chk("tx_flush_no_send", 32'(pulse_cnt), 32'(n0));

        // Reset while waiting for TxEngine to return idle
        port_wr(8'd1, 8'h3C);
        wait_pulses(n0 + 1, 50);
        chk("tx_byte_3c", 32'(tx_data), 32'h3C);
        tick(4);
        Rst = 1'b1;
        #1;
        chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
        chk("mid_rst_tx_data", 32'(tx_data), 32'h00);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        tick(2);
        Rst = 1'b0;
        tick(1);
        port_rd(8'd0, d);      chk("post_rst_status", 32'(d), 32'h0A);
        n0 = pulse_cnt;
        tick(20);              chk("post_rst_no_pulse", 32'(pulse_cnt), 32'(n0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
